// File: rtl/tm_accum_pkg.sv
// Shared widths, defaults and enums for the line-sum window accumulator.
// The default widths follow the pixel/line geometry of the upstream adder trees.
package tm_accum_pkg;

    localparam int NUM_TEMPLATES = 2;
    localparam int LINE_SIZE     = 64;
    localparam int PIXEL_SIZE    = 8;
    localparam int NUM_OF_LINES  = 8;

    typedef enum logic {
        WIN_SLIDING = 1'b0,
        WIN_BLOCK   = 1'b1
    } win_mode_e;

    typedef enum logic {
        WS_FILL = 1'b0,
        WS_FULL = 1'b1
    } win_state_e;

    function automatic int in_width(input int line_size, input int pixel_size);
        return $clog2(line_size) + 2 * pixel_size;
    endfunction

    // Enough headroom for WIN_LINES+1 maximal terms, so acc + new never wraps.
    function automatic int acc_width(input int in_w, input int win_lines);
        return in_w + $clog2(win_lines + 1);
    endfunction

    function automatic int cnt_width(input int win_lines);
        return $clog2(win_lines + 1);
    endfunction

endpackage

// File: rtl/line_sum_window_accumulator_if.sv
// Line-sum input stream and window-sum output bundle of the accumulator.
interface line_sum_window_accumulator_if
    import tm_accum_pkg::*;
#(
    parameter int NUM_CH    = 2 + NUM_TEMPLATES,
    parameter int IN_W      = in_width(LINE_SIZE, PIXEL_SIZE),
    parameter int WIN_LINES = NUM_OF_LINES
) ();
    localparam int ACC_W = acc_width(IN_W, WIN_LINES);
    localparam int CNT_W = cnt_width(WIN_LINES);

    logic                    frame_start;
    logic                    in_valid;
    logic [NUM_CH*IN_W-1:0]  line_sum;
    logic                    acc_valid;
    logic [NUM_CH*ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0]        lines_in_win;

    modport master (
        output frame_start, in_valid, line_sum,
        input  acc_valid, acc_sum, lines_in_win
    );

    modport slave (
        input  frame_start, in_valid, line_sum,
        output acc_valid, acc_sum, lines_in_win
    );

endinterface

// File: rtl/line_sum_delay_buffer.sv
// Circular line buffer; rd_data is the line that the next accepted write will overwrite,
// i.e. the line falling out of a full sliding window.
module line_sum_delay_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_reg;
    logic [PTR_W-1:0] ptr_reg, ptr_next, wr_addr;

    always_comb begin
        wr_addr  = clear ? '0 : ptr_reg;
        ptr_next = wr_addr;
        if (wr_en) begin
            ptr_next = (wr_addr == PTR_W'(DEPTH - 1)) ? '0 : wr_addr + PTR_W'(1);
        end
    end

    // Pre-fetch the slot the pointer will sit on next cycle, so the dropped line is
    // already registered when the following accept arrives.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_reg <= mem[ptr_next];
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/line_sum_window_accumulator.sv
// Per-channel window accumulator over WIN_LINES line sums, sliding or block mode.
// One shared FILL/FULL controller drives NUM_CH identical accumulator lanes.
module line_sum_window_accumulator
    import tm_accum_pkg::*;
#(
    parameter int        NUM_CH    = 2 + NUM_TEMPLATES,
    parameter int        IN_W      = in_width(LINE_SIZE, PIXEL_SIZE),
    parameter int        WIN_LINES = NUM_OF_LINES,
    parameter win_mode_e MODE      = WIN_SLIDING
) (
    input  logic                         CLK,
    input  logic                         reset,
    line_sum_window_accumulator_if.slave bus
);
    localparam int ACC_W = acc_width(IN_W, WIN_LINES);
    localparam int CNT_W = cnt_width(WIN_LINES);
    localparam int LS_W  = NUM_CH * IN_W;

    win_state_e       state_reg;
    logic [CNT_W-1:0] cnt_reg, base_cnt, cnt_inc;
    logic             acc_valid_reg;
    logic             eff_full, restart, sub_oldest;
    logic [LS_W-1:0]  oldest;

    // frame_start in the same cycle as an accept behaves as clear-then-accept.
    always_comb begin
        eff_full   = (state_reg == WS_FULL) && !bus.frame_start;
        restart    = bus.frame_start || ((MODE == WIN_BLOCK) && (state_reg == WS_FULL));
        sub_oldest = (MODE == WIN_SLIDING) && eff_full;
        base_cnt   = bus.frame_start ? '0 : cnt_reg;
        cnt_inc    = base_cnt + CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_reg     <= WS_FILL;
            cnt_reg       <= '0;
            acc_valid_reg <= 1'b0;
        end else begin
            acc_valid_reg <= 1'b0;
            if (bus.in_valid) begin
                if (eff_full && (MODE == WIN_SLIDING)) begin
                    acc_valid_reg <= 1'b1;
                end else if (eff_full) begin
                    state_reg <= WS_FILL;
                    cnt_reg   <= CNT_W'(1);
                end else begin
                    cnt_reg <= cnt_inc;
                    if (cnt_inc == CNT_W'(WIN_LINES)) begin
                        state_reg     <= WS_FULL;
                        acc_valid_reg <= 1'b1;
                    end else begin
                        state_reg <= WS_FILL;
                    end
                end
            end else if (bus.frame_start) begin
                state_reg <= WS_FILL;
                cnt_reg   <= '0;
            end
        end
    end

    generate
        if (MODE == WIN_SLIDING) begin : g_buf
            line_sum_delay_buffer #(
                .DEPTH (WIN_LINES),
                .WIDTH (LS_W)
            ) u_delay_buffer (
                .CLK     (CLK),
                .reset   (reset),
                .clear   (bus.frame_start),
                .wr_en   (bus.in_valid),
                .wr_data (bus.line_sum),
                .rd_data (oldest)
            );
        end else begin : g_no_buf
            assign oldest = '0;
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
            logic [ACC_W-1:0] acc_reg, acc_next, new_ext, old_ext;

            assign new_ext = ACC_W'(bus.line_sum[gi*IN_W +: IN_W]);
            assign old_ext = ACC_W'(oldest[gi*IN_W +: IN_W]);

            // The dropped line is part of acc_reg, so the subtraction cannot underflow.
            always_comb begin
                acc_next = acc_reg;
                if (bus.in_valid) begin
                    acc_next = (restart ? '0 : acc_reg) + new_ext - (sub_oldest ? old_ext : '0);
                end else if (bus.frame_start) begin
                    acc_next = '0;
                end
            end

            always_ff @(posedge CLK) begin
                if (reset) begin
                    acc_reg <= '0;
                end else begin
                    acc_reg <= acc_next;
                end
            end

            assign bus.acc_sum[gi*ACC_W +: ACC_W] = acc_reg;
        end
    endgenerate

    assign bus.acc_valid    = acc_valid_reg;
    assign bus.lines_in_win = cnt_reg;

endmodule

// File: tb/tb_line_sum_window_accumulator.sv
// Drives a sliding and a block instance with identical stimulus and compares both
// against a queue-based window model.
module tb_line_sum_window_accumulator;
    import tm_accum_pkg::*;

    localparam int NUM_CH = 3;
    localparam int IN_W   = 8;
    localparam int WIN    = 4;
    localparam int ACC_W  = acc_width(IN_W, WIN);
    localparam int CNT_W  = cnt_width(WIN);
    localparam int LS_W   = NUM_CH * IN_W;
    localparam int AS_W   = NUM_CH * ACC_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    line_sum_window_accumulator_if #(.NUM_CH(NUM_CH), .IN_W(IN_W), .WIN_LINES(WIN)) s_if ();
    line_sum_window_accumulator_if #(.NUM_CH(NUM_CH), .IN_W(IN_W), .WIN_LINES(WIN)) b_if ();

    line_sum_window_accumulator #(
        .NUM_CH(NUM_CH), .IN_W(IN_W), .WIN_LINES(WIN), .MODE(WIN_SLIDING)
    ) dut_s (
        .CLK   (clk),
        .reset (rst),
        .bus   (s_if)
    );

    line_sum_window_accumulator #(
        .NUM_CH(NUM_CH), .IN_W(IN_W), .WIN_LINES(WIN), .MODE(WIN_BLOCK)
    ) dut_b (
        .CLK   (clk),
        .reset (rst),
        .bus   (b_if)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: the lines currently in each window, kept as plain queues.
    logic [LS_W-1:0]  q_s[$];
    logic [LS_W-1:0]  q_b[$];
    logic             exp_s_valid, exp_b_valid;
    logic [AS_W-1:0]  exp_s_sum, exp_b_sum;
    logic [CNT_W-1:0] exp_s_lines, exp_b_lines;

    function automatic logic [AS_W-1:0] qsum(input logic [LS_W-1:0] q[$]);
        logic [AS_W-1:0] r;
        r = '0;
        foreach (q[i]) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r[c*ACC_W +: ACC_W] = r[c*ACC_W +: ACC_W] + ACC_W'(q[i][c*IN_W +: IN_W]);
            end
        end
        return r;
    endfunction

    task automatic cycle(input logic r, input logic fs, input logic iv, input logic [LS_W-1:0] ls);
        @(negedge clk);
        rst            = r;
        s_if.frame_start = fs;  s_if.in_valid = iv;  s_if.line_sum = ls;
        b_if.frame_start = fs;  b_if.in_valid = iv;  b_if.line_sum = ls;
        @(posedge clk);
        #1;
        exp_s_valid = 1'b0;
        exp_b_valid = 1'b0;
        if (r) begin
            q_s.delete();
            q_b.delete();
        end else begin
            if (fs) begin
                q_s.delete();
                q_b.delete();
            end
            if (iv) begin
                q_s.push_back(ls);
                if (q_s.size() > WIN) void'(q_s.pop_front());
                exp_s_valid = (q_s.size() == WIN);
                if (q_b.size() == WIN) q_b.delete();
                q_b.push_back(ls);
                exp_b_valid = (q_b.size() == WIN);
            end
        end
        exp_s_sum   = qsum(q_s);
        exp_b_sum   = qsum(q_b);
        exp_s_lines = CNT_W'(q_s.size());
        exp_b_lines = CNT_W'(q_b.size());
    endtask

    function automatic logic [LS_W-1:0] line_with_ch0(input int v);
        logic [LS_W-1:0] l;
        l = LS_W'($urandom);
        l[IN_W-1:0] = IN_W'(v);
        return l;
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'($urandom), 1'($urandom), LS_W'($urandom));
        total++;
        if ({s_if.acc_valid, s_if.acc_sum, s_if.lines_in_win} !== '0) begin
            bad++;
            $display("FAIL reset_slide got=%h want=0", {s_if.acc_valid, s_if.acc_sum, s_if.lines_in_win});
        end
        total++;
        if ({b_if.acc_valid, b_if.acc_sum, b_if.lines_in_win} !== '0) begin
            bad++;
            $display("FAIL reset_block got=%h want=0", {b_if.acc_valid, b_if.acc_sum, b_if.lines_in_win});
        end
        cycle(1'b0, 1'b0, 1'b0, '0);
        $display("test_reset done");
    endtask

    task automatic test_sliding();
        logic [ACC_W-1:0] got[$];
        int want[3] = '{10, 14, 18};
        cycle(1'b0, 1'b1, 1'b0, '0);
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b0, 1'b0, 1'b1, line_with_ch0(k));
            total++;
            if ({s_if.acc_valid, s_if.acc_sum, s_if.lines_in_win} !== {exp_s_valid, exp_s_sum, exp_s_lines}) begin
                bad++;
                $display("FAIL slide_model line=%0d got=%h want=%h", k,
                         {s_if.acc_valid, s_if.acc_sum, s_if.lines_in_win}, {exp_s_valid, exp_s_sum, exp_s_lines});
            end
            if (s_if.acc_valid) got.push_back(s_if.acc_sum[ACC_W-1:0]);
        end
        total++;
        if (got.size() != 3) begin
            bad++;
            $display("FAIL slide_pulses got=%0d want=3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (got[i] !== ACC_W'(want[i])) begin
                    bad++;
                    $display("FAIL slide_ch0 idx=%0d got=%0d want=%0d", i, got[i], want[i]);
                end
            end
        end
        $display("test_sliding done, pulses=%0d", got.size());
    endtask

    task automatic test_block();
        logic [ACC_W-1:0] got[$];
        int want[2] = '{10, 26};
        cycle(1'b0, 1'b1, 1'b0, '0);
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b0, 1'b0, 1'b1, line_with_ch0(k));
            total++;
            if ({b_if.acc_valid, b_if.acc_sum, b_if.lines_in_win} !== {exp_b_valid, exp_b_sum, exp_b_lines}) begin
                bad++;
                $display("FAIL block_model line=%0d got=%h want=%h", k,
                         {b_if.acc_valid, b_if.acc_sum, b_if.lines_in_win}, {exp_b_valid, exp_b_sum, exp_b_lines});
            end
            if (k == 4 || k == 5) begin
                total++;
                if (b_if.lines_in_win !== CNT_W'((k == 4) ? 4 : 1)) begin
                    bad++;
                    $display("FAIL block_lines line=%0d got=%0d want=%0d", k, b_if.lines_in_win, (k == 4) ? 4 : 1);
                end
            end
            if (b_if.acc_valid) got.push_back(b_if.acc_sum[ACC_W-1:0]);
        end
        total++;
        if (got.size() != 2 || got[0] !== ACC_W'(want[0]) || got[1] !== ACC_W'(want[1])) begin
            bad++;
            $display("FAIL block_ch0 got_count=%0d first=%0d want 10 then 26", got.size(),
                     (got.size() > 0) ? got[0] : 0);
        end
        $display("test_block done, pulses=%0d", got.size());
    endtask

    task automatic test_max();
        logic [AS_W-1:0] want;
        for (int c = 0; c < NUM_CH; c++) want[c*ACC_W +: ACC_W] = ACC_W'(WIN * (2**IN_W - 1));
        cycle(1'b0, 1'b1, 1'b0, '0);
        for (int k = 0; k < WIN; k++) cycle(1'b0, 1'b0, 1'b1, '1);
        total++;
        if (s_if.acc_valid !== 1'b1 || s_if.acc_sum !== want) begin
            bad++;
            $display("FAIL max_slide got v=%b sum=%h want v=1 sum=%h", s_if.acc_valid, s_if.acc_sum, want);
        end
        total++;
        if (b_if.acc_valid !== 1'b1 || b_if.acc_sum !== want) begin
            bad++;
            $display("FAIL max_block got v=%b sum=%h want v=1 sum=%h", b_if.acc_valid, b_if.acc_sum, want);
        end
        $display("test_max done");
    endtask

    task automatic test_frame_start();
        cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b1, line_with_ch0(1));
        cycle(1'b0, 1'b0, 1'b1, line_with_ch0(2));
        cycle(1'b0, 1'b1, 1'b1, line_with_ch0(7));
        total++;
        if (s_if.lines_in_win !== CNT_W'(1) || s_if.acc_sum[ACC_W-1:0] !== ACC_W'(7) || s_if.acc_valid !== 1'b0) begin
            bad++;
            $display("FAIL fs_accept got n=%0d ch0=%0d v=%b want n=1 ch0=7 v=0",
                     s_if.lines_in_win, s_if.acc_sum[ACC_W-1:0], s_if.acc_valid);
        end
        total++;
        if ({b_if.acc_valid, b_if.acc_sum, b_if.lines_in_win} !== {exp_b_valid, exp_b_sum, exp_b_lines}) begin
            bad++;
            $display("FAIL fs_accept_block got=%h want=%h",
                     {b_if.acc_valid, b_if.acc_sum, b_if.lines_in_win}, {exp_b_valid, exp_b_sum, exp_b_lines});
        end
        $display("test_frame_start done");
    endtask

    task automatic test_gaps();
        logic [ACC_W-1:0] got[$];
        int want[3] = '{10, 14, 18};
        cycle(1'b0, 1'b1, 1'b0, '0);
        for (int k = 1; k <= 6; k++) begin
            int gap = $urandom_range(0, 5);
            for (int g = 0; g <= gap; g++) begin
                cycle(1'b0, 1'b0, (g == gap), line_with_ch0(k));
                total++;
                if ({s_if.acc_valid, s_if.acc_sum, s_if.lines_in_win} !== {exp_s_valid, exp_s_sum, exp_s_lines}) begin
                    bad++;
                    $display("FAIL gaps_model line=%0d idle=%0d got=%h want=%h", k, g,
                             {s_if.acc_valid, s_if.acc_sum, s_if.lines_in_win}, {exp_s_valid, exp_s_sum, exp_s_lines});
                end
                if (s_if.acc_valid) got.push_back(s_if.acc_sum[ACC_W-1:0]);
            end
        end
        total++;
        if (got.size() != 3 || got[0] !== ACC_W'(want[0]) || got[1] !== ACC_W'(want[1]) || got[2] !== ACC_W'(want[2])) begin
            bad++;
            $display("FAIL gaps_seq got_count=%0d want 10,14,18", got.size());
        end
        $display("test_gaps done, pulses=%0d", got.size());
    endtask

    task automatic test_reset_mid();
        logic [ACC_W-1:0] got[$];
        cycle(1'b0, 1'b1, 1'b0, '0);
        for (int k = 1; k <= 5; k++) cycle(1'b0, 1'b0, 1'b1, line_with_ch0(k + 20));
        cycle(1'b1, 1'b0, 1'b1, line_with_ch0(9));
        total++;
        if ({s_if.acc_valid, s_if.acc_sum, s_if.lines_in_win} !== '0) begin
            bad++;
            $display("FAIL reset_mid got=%h want=0", {s_if.acc_valid, s_if.acc_sum, s_if.lines_in_win});
        end
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b0, 1'b0, 1'b1, line_with_ch0(k));
            if (s_if.acc_valid) got.push_back(s_if.acc_sum[ACC_W-1:0]);
        end
        total++;
        if (got.size() != 3 || got[0] !== ACC_W'(10) || got[1] !== ACC_W'(14) || got[2] !== ACC_W'(18)) begin
            bad++;
            $display("FAIL reset_refill got_count=%0d want 10,14,18", got.size());
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic r, fs, iv;
            r  = ($urandom_range(0, 63) == 0);
            fs = ($urandom_range(0, 15) == 0);
            iv = ($urandom_range(0, 1) == 1);
            cycle(r, fs, iv, LS_W'($urandom));
            total++;
            if ({s_if.acc_valid, s_if.acc_sum, s_if.lines_in_win} !== {exp_s_valid, exp_s_sum, exp_s_lines}) begin
                bad++;
                $display("FAIL rand_slide i=%0d got=%h want=%h", i,
                         {s_if.acc_valid, s_if.acc_sum, s_if.lines_in_win}, {exp_s_valid, exp_s_sum, exp_s_lines});
            end
            total++;
            if ({b_if.acc_valid, b_if.acc_sum, b_if.lines_in_win} !== {exp_b_valid, exp_b_sum, exp_b_lines}) begin
                bad++;
                $display("FAIL rand_block i=%0d got=%h want=%h", i,
                         {b_if.acc_valid, b_if.acc_sum, b_if.lines_in_win}, {exp_b_valid, exp_b_sum, exp_b_lines});
            end
        end
        $display("test_random done");
    endtask

    initial begin
        s_if.frame_start = 1'b0;  s_if.in_valid = 1'b0;  s_if.line_sum = '0;
        b_if.frame_start = 1'b0;  b_if.in_valid = 1'b0;  b_if.line_sum = '0;
        test_reset();
        test_sliding();
        test_block();
        test_max();
        test_frame_start();
        test_gaps();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
